// File: rtl/scoreboard_pkg.sv
// Shared types and helpers for the issue scoreboard.
//   fu_state_t : per-FU lifecycle (IDLE -> WAIT_OPS -> EXEC -> WB_WAIT)
//   CLS_MATH / CLS_MEM : instruction/FU class encodings (matches issue_is_mem)
//   no_fu()    : the "no producing FU" code, equal to the FU count
package scoreboard_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OPS = 2'd1,
        EXEC     = 2'd2,
        WB_WAIT  = 2'd3
    } fu_state_t;

    localparam logic CLS_MATH = 1'b0;
    localparam logic CLS_MEM  = 1'b1;

    function automatic int no_fu(input int num_fu);
        return num_fu;
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode/FU-side bundle of the issue scoreboard.
//   master : decode + functional units (drive issue request and exec_done)
//   slave  : scoreboard (drives stall/fire/fu and the read/write-back grants)
interface issue_scoreboard_if #(
    parameter int NUM_FU = 3,
    parameter int REG_AW = 3,
    parameter int FU_AW  = 2
);
    logic              issue_valid;
    logic              issue_is_mem;
    logic [REG_AW-1:0] issue_dest;
    logic [REG_AW-1:0] issue_src0;
    logic [REG_AW-1:0] issue_src1;
    logic              issue_stall;
    logic              issue_fire;
    logic [FU_AW-1:0]  issue_fu;
    logic [NUM_FU-1:0] read_grant;
    logic [NUM_FU-1:0] exec_done;
    logic [NUM_FU-1:0] wb_grant;

    modport master (
        output issue_valid, issue_is_mem, issue_dest, issue_src0, issue_src1, exec_done,
        input  issue_stall, issue_fire, issue_fu, read_grant, wb_grant
    );

    modport slave (
        input  issue_valid, issue_is_mem, issue_dest, issue_src0, issue_src1, exec_done,
        output issue_stall, issue_fire, issue_fu, read_grant, wb_grant
    );
endinterface

// File: rtl/sb_fu_slot.sv
// One functional-unit slot of the scoreboard: lifecycle FSM plus the
// Fi/Fj/Fk register fields, Qj/Qk producer tags and Rj/Rk ready flags.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load            this slot is chosen by the issue arbiter this cycle
//   dest/src0/src1  instruction registers captured on load
//   q_src0/q_src1   current register-status producers of the sources
//   exec_done       unit result latched (only honoured in EXEC)
//   wb_all          write-back grants of all slots this cycle
//   idle/waiting/wb_wait  state decodes for the top level
//   read_grant      operand read pulse (WAIT_OPS with both sources ready)
//   fi/fj/fk/rj/rk  fields exported for the WAR check
module sb_fu_slot
    import scoreboard_pkg::*;
#(
    parameter int NUM_FU  = 3,
    parameter int REG_AW  = 3,
    parameter int FU_AW   = 2,
    parameter int SLOT_ID = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [REG_AW-1:0] dest,
    input  logic [REG_AW-1:0] src0,
    input  logic [REG_AW-1:0] src1,
    input  logic [FU_AW-1:0]  q_src0,
    input  logic [FU_AW-1:0]  q_src1,
    input  logic              exec_done,
    input  logic [NUM_FU-1:0] wb_all,
    output logic              idle,
    output logic              waiting,
    output logic              wb_wait,
    output logic              read_grant,
    output logic [REG_AW-1:0] fi,
    output logic [REG_AW-1:0] fj,
    output logic [REG_AW-1:0] fk,
    output logic              rj,
    output logic              rk
);
    localparam logic [FU_AW-1:0] NO_FU = FU_AW'(no_fu(NUM_FU));

    fu_state_t         state_reg;
    logic [REG_AW-1:0] fi_reg, fj_reg, fk_reg;
    logic [FU_AW-1:0]  qj_reg, qk_reg;
    logic              rj_reg, rk_reg;

    // True when producer q is writing back this very cycle.
    function automatic logic q_hit(input logic [FU_AW-1:0] q, input logic [NUM_FU-1:0] wb);
        q_hit = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (q == FU_AW'(k) && wb[k]) q_hit = 1'b1;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            fi_reg    <= '0;
            fj_reg    <= '0;
            fk_reg    <= '0;
            qj_reg    <= NO_FU;
            qk_reg    <= NO_FU;
            rj_reg    <= 1'b0;
            rk_reg    <= 1'b0;
        end else begin
            // Producer release; the case below overrides on load/read.
            if (q_hit(qj_reg, wb_all)) begin
                rj_reg <= 1'b1;
                qj_reg <= NO_FU;
            end
            if (q_hit(qk_reg, wb_all)) begin
                rk_reg <= 1'b1;
                qk_reg <= NO_FU;
            end
            case (state_reg)
                IDLE: if (load) begin
                    state_reg <= WAIT_OPS;
                    fi_reg    <= dest;
                    fj_reg    <= src0;
                    fk_reg    <= src1;
                    // A producer finishing in the issue cycle counts as already done.
                    qj_reg    <= q_hit(q_src0, wb_all) ? NO_FU : q_src0;
                    qk_reg    <= q_hit(q_src1, wb_all) ? NO_FU : q_src1;
                    rj_reg    <= (q_src0 == NO_FU) || q_hit(q_src0, wb_all);
                    rk_reg    <= (q_src1 == NO_FU) || q_hit(q_src1, wb_all);
                end
                WAIT_OPS: if (rj_reg && rk_reg) begin
                    rj_reg    <= 1'b0;
                    rk_reg    <= 1'b0;
                    state_reg <= EXEC;
                end
                EXEC: if (exec_done) state_reg <= WB_WAIT;
                WB_WAIT: if (wb_all[SLOT_ID]) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign idle       = (state_reg == IDLE);
    assign waiting    = (state_reg == WAIT_OPS);
    assign wb_wait    = (state_reg == WB_WAIT);
    assign read_grant = (state_reg == WAIT_OPS) && rj_reg && rk_reg;
    assign fi = fi_reg;
    assign fj = fj_reg;
    assign fk = fk_reg;
    assign rj = rj_reg;
    assign rk = rk_reg;
endmodule

// File: rtl/issue_scoreboard.sv
// CDC6600-style issue scoreboard for NUM_FU units and NUM_REGS registers.
// Owns the register-status table, the issue arbiter and the WAR matrix;
// per-unit state lives in sb_fu_slot instances.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   sb          slave side of issue_scoreboard_if (issue request/decision,
//               read_grant, exec_done, wb_grant)
//   stall_cnt, waw_cnt  saturating stall statistics, present only when
//               SCOREBOARD_STATS_EN is defined
// Register NUM_REGS-1 is a discard target: never reserved, never WAW-stalls.
module issue_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int              NUM_FU      = 3,
    parameter int              NUM_REGS    = 8,
    parameter int              REG_AW      = 3,
    parameter int              FU_AW       = 2,
    parameter logic [NUM_FU-1:0] FU_MEM_MASK = 3'b100
) (
    input  logic clk,
    input  logic reset,
`ifdef SCOREBOARD_STATS_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] waw_cnt,
`endif
    issue_scoreboard_if.slave sb
);
    localparam logic [FU_AW-1:0]  NO_FU   = FU_AW'(no_fu(NUM_FU));
    localparam logic [REG_AW-1:0] DISCARD = REG_AW'(NUM_REGS - 1);

    logic [FU_AW-1:0]  rs_reg [NUM_REGS];
    logic [NUM_FU-1:0] fu_idle, fu_wait, fu_wbw, rd_vec, rj_vec, rk_vec;
    logic [NUM_FU-1:0] cls_ok, free_mask, load_vec, war_hit, wb_grant;
    logic [REG_AW-1:0] fi_arr [NUM_FU];
    logic [REG_AW-1:0] fj_arr [NUM_FU];
    logic [REG_AW-1:0] fk_arr [NUM_FU];
    logic [FU_AW-1:0]  sel;
    logic              waw, fire, dest_discard;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_slot
            assign cls_ok[gi]   = FU_MEM_MASK[gi] ? (sb.issue_is_mem == CLS_MEM)
                                                  : (sb.issue_is_mem == CLS_MATH);
            assign load_vec[gi] = fire && (sel == FU_AW'(gi));

            sb_fu_slot #(
                .NUM_FU(NUM_FU), .REG_AW(REG_AW), .FU_AW(FU_AW), .SLOT_ID(gi)
            ) u_slot (
                .clk        (clk),
                .reset      (reset),
                .load       (load_vec[gi]),
                .dest       (sb.issue_dest),
                .src0       (sb.issue_src0),
                .src1       (sb.issue_src1),
                .q_src0     (rs_reg[sb.issue_src0]),
                .q_src1     (rs_reg[sb.issue_src1]),
                .exec_done  (sb.exec_done[gi]),
                .wb_all     (wb_grant),
                .idle       (fu_idle[gi]),
                .waiting    (fu_wait[gi]),
                .wb_wait    (fu_wbw[gi]),
                .read_grant (rd_vec[gi]),
                .fi         (fi_arr[gi]),
                .fj         (fj_arr[gi]),
                .fk         (fk_arr[gi]),
                .rj         (rj_vec[gi]),
                .rk         (rk_vec[gi])
            );
        end
    endgenerate

    assign free_mask    = fu_idle & cls_ok;
    assign dest_discard = (sb.issue_dest == DISCARD);
    // WAW looks at the registered status only, so a same-cycle release
    // still stalls for this cycle.
    assign waw  = !dest_discard && (rs_reg[sb.issue_dest] != NO_FU);
    assign fire = sb.issue_valid && (|free_mask) && !waw;

    // Lowest-index free unit of the right class.
    always_comb begin
        sel = NO_FU;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (free_mask[i]) sel = FU_AW'(i);
        end
    end

    // Unit i may not write back while some waiting unit still needs the old
    // value of Fi[i] (source marked ready but not yet read).
    always_comb begin
        war_hit = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            for (int j = 0; j < NUM_FU; j++) begin
                if (fu_wait[j] && ((fj_arr[j] == fi_arr[i] && rj_vec[j]) ||
                                   (fk_arr[j] == fi_arr[i] && rk_vec[j])))
                    war_hit[i] = 1'b1;
            end
        end
    end
    assign wb_grant = fu_wbw & ~war_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) rs_reg[r] <= NO_FU;
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (wb_grant[f]) rs_reg[fi_arr[f]] <= NO_FU;
            end
            if (fire && !dest_discard) rs_reg[sb.issue_dest] <= sel;
        end
    end

    assign sb.issue_fire  = fire;
    assign sb.issue_stall = sb.issue_valid && !fire;
    assign sb.issue_fu    = fire ? sel : NO_FU;
    assign sb.read_grant  = rd_vec;
    assign sb.wb_grant    = wb_grant;

`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stall_cnt_reg, waw_cnt_reg;
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            waw_cnt_reg   <= '0;
        end else begin
            if (sb.issue_stall && stall_cnt_reg != 16'hFFFF)
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            if (sb.issue_stall && (|free_mask) && waw_cnt_reg != 16'hFFFF)
                waw_cnt_reg <= waw_cnt_reg + 16'd1;
        end
    end
    assign stall_cnt = stall_cnt_reg;
    assign waw_cnt   = waw_cnt_reg;
`endif
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard (default 3 FUs: FU0/FU1 math, FU2 mem).
// Expected issue FU / read grant / write-back grant events are queued as the
// stimulus is driven and popped by a monitor as the DUT pulses them; each step
// also checks the full output vector for that cycle.
`timescale 1ns/1ps
module tb_issue_scoreboard;
    localparam int NUM_FU = 3, NUM_REGS = 8, REG_AW = 3, FU_AW = 2;
    localparam int NOFU = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    issue_scoreboard_if #(.NUM_FU(NUM_FU), .REG_AW(REG_AW), .FU_AW(FU_AW)) sbif ();

`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stall_cnt, waw_cnt;
`endif

    issue_scoreboard #(
        .NUM_FU(NUM_FU), .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .FU_AW(FU_AW),
        .FU_MEM_MASK(3'b100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef SCOREBOARD_STATS_EN
        .stall_cnt (stall_cnt),
        .waw_cnt   (waw_cnt),
`endif
        .sb        (sbif)
    );

    int n_cmp = 0;
    int n_err = 0;
    int iss_q[$];
    int rd_q[$];
    int wb_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic m, input int d, input int s0, input int s1,
                       input logic [2:0] done);
        @(negedge clk);
        sbif.issue_valid  = v;
        sbif.issue_is_mem = m;
        sbif.issue_dest   = 3'(d);
        sbif.issue_src0   = 3'(s0);
        sbif.issue_src1   = 3'(s1);
        sbif.exec_done    = done;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 0, 0, 0, 3'b000);
    endtask

    task automatic outs(input string tag, input logic st, input logic fi, input int fu,
                        input logic [2:0] rg, input logic [2:0] wg);
        chk({tag, ".stall"}, int'(sbif.issue_stall), int'(st));
        chk({tag, ".fire"},  int'(sbif.issue_fire),  int'(fi));
        chk({tag, ".fu"},    int'(sbif.issue_fu),    fu);
        chk({tag, ".rdg"},   int'(sbif.read_grant),  int'(rg));
        chk({tag, ".wbg"},   int'(sbif.wb_grant),    int'(wg));
        $display("step %s stall=%0d fire=%0d fu=%0d rdg=%b wbg=%b", tag,
                 sbif.issue_stall, sbif.issue_fire, sbif.issue_fu, sbif.read_grant, sbif.wb_grant);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sbif.issue_valid = 1'b0; sbif.issue_is_mem = 1'b0;
        sbif.issue_dest = '0; sbif.issue_src0 = '0; sbif.issue_src1 = '0;
        sbif.exec_done = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset.qempty", iss_q.size() + rd_q.size() + wb_q.size(), 0);
    endtask

    // Event monitor: pops the expected unit for every pulse the DUT produces.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (sbif.issue_fire)
                    chk("mon.issue_fu", int'(sbif.issue_fu), iss_q.size() > 0 ? iss_q.pop_front() : -1);
                for (int i = 0; i < NUM_FU; i++) begin
                    if (sbif.read_grant[i])
                        chk("mon.read_fu", i, rd_q.size() > 0 ? rd_q.pop_front() : -1);
                    if (sbif.wb_grant[i])
                        chk("mon.wb_fu", i, wb_q.size() > 0 ? wb_q.pop_front() : -1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: single add, reset state
        do_reset();
        outs("reset", 0, 0, NOFU, 3'b000, 3'b000);
        iss_q.push_back(0); rd_q.push_back(0);
        drv(1, 0, 1, 2, 3, 3'b000); outs("t1.issue", 0, 1, 0,    3'b000, 3'b000);
        idle();                     outs("t1.read",  0, 0, NOFU, 3'b001, 3'b000);
        drv(0, 0, 0, 0, 0, 3'b001); outs("t1.done",  0, 0, NOFU, 3'b000, 3'b000);
        wb_q.push_back(0);
        idle();                     outs("t1.wb",    0, 0, NOFU, 3'b000, 3'b001);
        idle();                     outs("t1.quiet", 0, 0, NOFU, 3'b000, 3'b000);

        // 2: structural stall with both math units busy
        do_reset();
        iss_q.push_back(0); rd_q.push_back(0);
        drv(1, 0, 1, 0, 0, 3'b000); outs("t2.a",     0, 1, 0,    3'b000, 3'b000);
        iss_q.push_back(1); rd_q.push_back(1);
        drv(1, 0, 2, 0, 0, 3'b000); outs("t2.b",     0, 1, 1,    3'b001, 3'b000);
        drv(1, 0, 3, 0, 0, 3'b000); outs("t2.stall", 1, 0, NOFU, 3'b010, 3'b000);
        drv(1, 0, 3, 0, 0, 3'b011); outs("t2.done",  1, 0, NOFU, 3'b000, 3'b000);
        wb_q.push_back(0); wb_q.push_back(1);
        drv(1, 0, 3, 0, 0, 3'b000); outs("t2.wb",    1, 0, NOFU, 3'b000, 3'b011);
        iss_q.push_back(0); rd_q.push_back(0);
        drv(1, 0, 3, 0, 0, 3'b000); outs("t2.fire",  0, 1, 0,    3'b000, 3'b000);
        idle();                     outs("t2.read",  0, 0, NOFU, 3'b001, 3'b000);

        // 3: RAW dependency on r1
        do_reset();
        iss_q.push_back(0); rd_q.push_back(0);
        drv(1, 0, 1, 2, 3, 3'b000); outs("t3.a",     0, 1, 0,    3'b000, 3'b000);
        iss_q.push_back(1);
        drv(1, 0, 4, 1, 2, 3'b000); outs("t3.b",     0, 1, 1,    3'b001, 3'b000);
        drv(0, 0, 0, 0, 0, 3'b001); outs("t3.wait",  0, 0, NOFU, 3'b000, 3'b000);
        wb_q.push_back(0);
        idle();                     outs("t3.wb0",   0, 0, NOFU, 3'b000, 3'b001);
        rd_q.push_back(1);
        idle();                     outs("t3.rd1",   0, 0, NOFU, 3'b010, 3'b000);
        drv(0, 0, 0, 0, 0, 3'b010); outs("t3.done1", 0, 0, NOFU, 3'b000, 3'b000);
        wb_q.push_back(1);
        idle();                     outs("t3.wb1",   0, 0, NOFU, 3'b000, 3'b010);

        // 4: WAW on r1 between math and mem units
        do_reset();
        iss_q.push_back(0); rd_q.push_back(0);
        drv(1, 0, 1, 0, 0, 3'b000); outs("t4.a",     0, 1, 0,    3'b000, 3'b000);
        drv(1, 1, 1, 2, 3, 3'b000); outs("t4.waw1",  1, 0, NOFU, 3'b001, 3'b000);
        drv(1, 1, 1, 2, 3, 3'b001); outs("t4.waw2",  1, 0, NOFU, 3'b000, 3'b000);
        wb_q.push_back(0);
        drv(1, 1, 1, 2, 3, 3'b000); outs("t4.waw3",  1, 0, NOFU, 3'b000, 3'b001);
        iss_q.push_back(2); rd_q.push_back(2);
        drv(1, 1, 1, 2, 3, 3'b000); outs("t4.fire",  0, 1, 2,    3'b000, 3'b000);
        idle();                     outs("t4.read",  0, 0, NOFU, 3'b100, 3'b000);

        // 5: WAR hold on r5
        do_reset();
        iss_q.push_back(2); rd_q.push_back(2);
        drv(1, 1, 6, 0, 0, 3'b000); outs("t5.ld",    0, 1, 2,    3'b000, 3'b000);
        iss_q.push_back(0); rd_q.push_back(0);
        drv(1, 0, 1, 0, 0, 3'b000); outs("t5.a",     0, 1, 0,    3'b100, 3'b000);
        iss_q.push_back(1);
        drv(1, 0, 2, 5, 6, 3'b000); outs("t5.rd",    0, 1, 1,    3'b001, 3'b000);
        drv(0, 0, 0, 0, 0, 3'b001); outs("t5.d0",    0, 0, NOFU, 3'b000, 3'b000);
        wb_q.push_back(0);
        idle();                     outs("t5.wb0a",  0, 0, NOFU, 3'b000, 3'b001);
        iss_q.push_back(0); rd_q.push_back(0);
        drv(1, 0, 5, 0, 0, 3'b000); outs("t5.w5",    0, 1, 0,    3'b000, 3'b000);
        idle();                     outs("t5.rdw5",  0, 0, NOFU, 3'b001, 3'b000);
        drv(0, 0, 0, 0, 0, 3'b001); outs("t5.dw5",   0, 0, NOFU, 3'b000, 3'b000);
        idle();                     outs("t5.war1",  0, 0, NOFU, 3'b000, 3'b000);
        drv(0, 0, 0, 0, 0, 3'b100); outs("t5.war2",  0, 0, NOFU, 3'b000, 3'b000);
        wb_q.push_back(2);
        idle();                     outs("t5.wb2",   0, 0, NOFU, 3'b000, 3'b100);
        rd_q.push_back(1);
        idle();                     outs("t5.rd1",   0, 0, NOFU, 3'b010, 3'b000);
        wb_q.push_back(0);
        idle();                     outs("t5.wb0b",  0, 0, NOFU, 3'b000, 3'b001);

        // 6: reset mid-EXEC, discard destination, ignored exec_done
        do_reset();
        iss_q.push_back(0); rd_q.push_back(0);
        drv(1, 0, 1, 0, 0, 3'b000); outs("t6.a",     0, 1, 0,    3'b000, 3'b000);
        idle();                     outs("t6.rd",    0, 0, NOFU, 3'b001, 3'b000);
        idle();                     outs("t6.exec",  0, 0, NOFU, 3'b000, 3'b000);
        do_reset();
        outs("t6.rst", 0, 0, NOFU, 3'b000, 3'b000);
        iss_q.push_back(0);
        drv(1, 0, 1, 1, 2, 3'b001); outs("t6.reiss", 0, 1, 0,    3'b000, 3'b000);
        iss_q.push_back(2); rd_q.push_back(0);
        drv(1, 1, 7, 0, 0, 3'b001); outs("t6.d7m",   0, 1, 2,    3'b001, 3'b000);
        iss_q.push_back(1); rd_q.push_back(2);
        drv(1, 0, 7, 0, 0, 3'b000); outs("t6.d7a",   0, 1, 1,    3'b100, 3'b000);
        rd_q.push_back(1);
        idle();                     outs("t6.rd1",   0, 0, NOFU, 3'b010, 3'b000);
        idle();                     outs("t6.nowb",  0, 0, NOFU, 3'b000, 3'b000);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
